// File: rtl/reg_port_arbiter.sv
// Shares the register stack's single get/set port between one reader and two writers.
// Only one stack operation is issued per cycle, read-after-write hazards are held off,
// and a streak limit keeps back-to-back writes from starving the reader.
module reg_port_arbiter #(
  parameter int unsigned NIB_SIZE     = 4,
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [NIB_SIZE-1:0]  rd_num1,
  input  logic [NIB_SIZE-1:0]  rd_num2,
  output logic                 rd_ack,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data1,
  output logic [WORD_SIZE-1:0] rd_data2,
  input  logic                 wa_req,
  input  logic [NIB_SIZE-1:0]  wa_num,
  input  logic [WORD_SIZE-1:0] wa_val,
  output logic                 wa_ack,
  input  logic                 wb_req,
  input  logic [NIB_SIZE-1:0]  wb_num,
  input  logic [WORD_SIZE-1:0] wb_val,
  output logic                 wb_ack,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_get_enable,
  output logic                 rs_set_enable,
  output logic                 rs_reset_enable,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2,
  output logic                 rd_hazard
);

  localparam int unsigned STREAK_W = 3;
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_MAX   = '1;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

  ptr_t                 ptr, ptr_n;
  logic [STREAK_W-1:0]  streak, streak_n;
  logic                 rd_elig, wa_elig, wb_elig, hazard, rd_ok;
  logic                 rd_ack_n, wa_ack_n, wb_ack_n, rd_valid_n;
  logic                 get_en_n, set_en_n;
  logic [NIB_SIZE-1:0]  num1_n, num2_n, setnum_n;
  logic [WORD_SIZE-1:0] setval_n;

  // A requester whose ack is currently high is still dropping req and must not be regranted.
  assign rd_elig = rd_req & ~rd_ack;
  assign wa_elig = wa_req & ~wa_ack;
  assign wb_elig = wb_req & ~wb_ack;

  assign hazard = (wa_elig & ((wa_num == rd_num1) | (wa_num == rd_num2))) |
                  (wb_elig & ((wb_num == rd_num1) | (wb_num == rd_num2)));
  assign rd_ok     = rd_elig & ~hazard;
  assign rd_hazard = rd_req & hazard;

  assign rd_data1 = rs_out1;
  assign rd_data2 = rs_out2;

  // Grant selection, round-robin pointer and starvation streak.
  always_comb begin
    ptr_n      = ptr;
    streak_n   = streak;
    rd_ack_n   = 1'b0;
    wa_ack_n   = 1'b0;
    wb_ack_n   = 1'b0;
    get_en_n   = 1'b0;
    set_en_n   = 1'b0;
    rd_valid_n = rs_get_enable;
    num1_n     = rs_num1;
    num2_n     = rs_num2;
    setnum_n   = rs_setnum;
    setval_n   = rs_setval;

    if (rd_ok && (streak >= STREAK_LIMIT)) begin
      rd_ack_n = 1'b1;
      get_en_n = 1'b1;
      num1_n   = rd_num1;
      num2_n   = rd_num2;
    end else if (wa_elig || wb_elig) begin
      set_en_n = 1'b1;
      if (wa_elig && (!wb_elig || (ptr == PTR_A))) begin
        wa_ack_n = 1'b1;
        setnum_n = wa_num;
        setval_n = wa_val;
        ptr_n    = PTR_B;
      end else begin
        wb_ack_n = 1'b1;
        setnum_n = wb_num;
        setval_n = wb_val;
        ptr_n    = PTR_A;
      end
      if (rd_ok && (streak != STREAK_MAX)) begin
        streak_n = streak + STREAK_W'(1);
      end
    end else if (rd_ok) begin
      rd_ack_n = 1'b1;
      get_en_n = 1'b1;
      num1_n   = rd_num1;
      num2_n   = rd_num2;
    end

    if (rd_ack_n || !rd_req) begin
      streak_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= PTR_A;
      streak          <= '0;
      rd_ack          <= 1'b0;
      wa_ack          <= 1'b0;
      wb_ack          <= 1'b0;
      rd_valid        <= 1'b0;
      rs_get_enable   <= 1'b0;
      rs_set_enable   <= 1'b0;
      rs_reset_enable <= 1'b1;
      rs_num1         <= '0;
      rs_num2         <= '0;
      rs_setnum       <= '0;
      rs_setval       <= '0;
    end else begin
      ptr             <= ptr_n;
      streak          <= streak_n;
      rd_ack          <= rd_ack_n;
      wa_ack          <= wa_ack_n;
      wb_ack          <= wb_ack_n;
      rd_valid        <= rd_valid_n;
      rs_get_enable   <= get_en_n;
      rs_set_enable   <= set_en_n;
      rs_reset_enable <= 1'b0;
      rs_num1         <= num1_n;
      rs_num2         <= num2_n;
      rs_setnum       <= setnum_n;
      rs_setval       <= setval_n;
    end
  end

endmodule
